// File: rtl/master_input_control_if.sv
// Bundle between the master controller, the input-side read sequencer and the
// per-row input memory banks. The master modport is the controlling side
// (issues start and the read geometry, observes the bank read strobes); the
// slave modport is the read sequencer itself.
interface master_input_control_if #(
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH   = 8
);
    localparam int ROW_W = $clog2(SYS_ARR_ROWS);
    localparam int COL_W = $clog2(SYS_ARR_COLS);

    logic                                 start;
    logic                                 done;
    logic [ADDR_WIDTH-1:0]                rd_base_addr;
    logic [ROW_W-1:0]                     num_rows_read;
    logic [COL_W-1:0]                     num_cols_read;
    logic [SYS_ARR_ROWS-1:0]              rd_en;
    logic [SYS_ARR_ROWS*ADDR_WIDTH-1:0]   rd_addr;
    logic [SYS_ARR_ROWS-1:0]              data_valid;

    modport master (
        output start,
        output rd_base_addr,
        output num_rows_read,
        output num_cols_read,
        input  done,
        input  rd_en,
        input  rd_addr,
        input  data_valid
    );

    modport slave (
        input  start,
        input  rd_base_addr,
        input  num_rows_read,
        input  num_cols_read,
        output done,
        output rd_en,
        output rd_addr,
        output data_valid
    );
endinterface

// File: rtl/master_input_control.sv
// Input-side read sequencer. On start it walks one input submatrix out of the
// per-row input banks. Bank i trails bank 0 by i cycles so operands reach the
// systolic array on a diagonal wavefront; data_valid follows rd_en by the
// one-cycle bank read latency.
module master_input_control #(
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH   = 8
) (
    input logic                     clk,
    input logic                     reset,
    master_input_control_if.slave   bus
);
    localparam int ROW_W = $clog2(SYS_ARR_ROWS);
    localparam int COL_W = $clog2(SYS_ARR_COLS);
    localparam int CNT_W = $clog2(SYS_ARR_ROWS + SYS_ARR_COLS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ROW_W-1:0]        rows_q, rows_d;
    logic [COL_W-1:0]        cols_q, cols_d;
    logic [SYS_ARR_ROWS-1:0] data_valid_q;

    logic                    started;
    logic [CNT_W-1:0]        cols_ext;
    logic [CNT_W-1:0]        last_count;
    logic [SYS_ARR_ROWS-1:0] rd_en_w;
    logic [SYS_ARR_ROWS*ADDR_WIDTH-1:0] rd_addr_w;

    // The final count is R+C: bank R is the last to start and it streams C+1 words.
    assign cols_ext   = CNT_W'(cols_q);
    assign last_count = CNT_W'(rows_q) + cols_ext;
    assign started    = (state_q == ST_RUN);

    // State register: sequencer state, cycle counter and the latched read geometry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            base_q  <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            base_q  <= base_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
        end
    end

    // Next-state logic: geometry is captured only on an accepted start, so
    // input changes and stray start pulses mid-run are ignored.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        base_d  = base_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    base_d  = bus.rd_base_addr;
                    rows_d  = bus.num_rows_read;
                    cols_d  = bus.num_cols_read;
                end
            end
            ST_RUN: begin
                if (count_q == last_count) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Per-bank skewed read window: bank gi is live while 0 <= count-gi <= C,
    // and only for banks up to R. Idle banks park their address at the base.
    for (genvar gi = 0; gi < SYS_ARR_ROWS; gi++) begin : g_bank
        localparam logic [CNT_W-1:0] BANK_OFS = CNT_W'(gi);
        localparam logic [ROW_W-1:0] BANK_IDX = ROW_W'(gi);

        logic [CNT_W-1:0] offset;
        logic             bank_en;

        assign offset  = count_q - BANK_OFS;
        assign bank_en = started
                      && (BANK_IDX <= rows_q)
                      && (count_q >= BANK_OFS)
                      && (offset <= cols_ext);

        assign rd_en_w[gi] = bank_en;
        // Address arithmetic is modulo 2^ADDR_WIDTH; wrap-around is intentional.
        assign rd_addr_w[gi*ADDR_WIDTH +: ADDR_WIDTH] =
            bank_en ? (base_q + ADDR_WIDTH'(offset)) : base_q;
    end

    // Output logic: done is simply the idle indication; strobes come from the bank windows.
    always_comb begin
        bus.done    = ~started;
        bus.rd_en   = rd_en_w;
        bus.rd_addr = rd_addr_w;
    end

    // Read data appears one cycle after the enable, so valid is the enable delayed once.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_valid_q <= '0;
        end else begin
            data_valid_q <= rd_en_w;
        end
    end

    assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_master_input_control.sv
// Directed bench for master_input_control: reset state, full and partial skewed
// reads, address wrap, mid-run input/start immunity, mid-run reset, reset vs
// start priority and back-to-back start on the done-rise cycle.
module tb_master_input_control;
    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int AW   = 8;

    logic clk;
    logic reset;

    int tests_run;
    int tests_failed;

    master_input_control_if #(
        .SYS_ARR_ROWS(ROWS),
        .SYS_ARR_COLS(COLS),
        .ADDR_WIDTH  (AW)
    ) bus ();

    master_input_control #(
        .SYS_ARR_ROWS(ROWS),
        .SYS_ARR_COLS(COLS),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start for one edge with the given geometry; returns on the negedge of cycle 0.
    task automatic do_start(input logic [7:0] b, input logic [3:0] r, input logic [3:0] c);
        bus.start         = 1'b1;
        bus.rd_base_addr  = b;
        bus.num_rows_read = r;
        bus.num_cols_read = c;
        @(negedge clk);
        bus.start = 1'b0;
        $display("[TB] start B=%0h R=%0d C=%0d", b, r, c);
    endtask

    // Walk a whole sequence checking every bank against the skewed-window rule,
    // then the idle cycle where done rises.
    task automatic run_seq(input string name, input logic [7:0] b, input int r, input int c);
        logic [15:0]  prev_en;
        logic [15:0]  en;
        logic [127:0] addr;
        prev_en = '0;
        for (int k = 0; k <= r + c; k++) begin
            en   = '0;
            addr = '0;
            for (int bk = 0; bk < ROWS; bk++) begin
                addr[bk*8 +: 8] = b;
                if (bk <= r && k >= bk && (k - bk) <= c) begin
                    en[bk]          = 1'b1;
                    addr[bk*8 +: 8] = 8'(int'(b) + k - bk);
                end
            end
            check($sformatf("%s done k=%0d", name, k), 128'(bus.done), 128'(1'b0));
            check($sformatf("%s rd_en k=%0d", name, k), 128'(bus.rd_en), 128'(en));
            check($sformatf("%s rd_addr k=%0d", name, k), bus.rd_addr, addr);
            check($sformatf("%s dvalid k=%0d", name, k), 128'(bus.data_valid), 128'(prev_en));
            prev_en = en;
            @(negedge clk);
        end
        addr = '0;
        for (int bk = 0; bk < ROWS; bk++) addr[bk*8 +: 8] = b;
        check($sformatf("%s done end", name), 128'(bus.done), 128'(1'b1));
        check($sformatf("%s rd_en end", name), 128'(bus.rd_en), 128'(0));
        check($sformatf("%s rd_addr end", name), bus.rd_addr, addr);
        check($sformatf("%s dvalid end", name), 128'(bus.data_valid), 128'(prev_en));
        $display("[TB] %s sequence of %0d cycles complete", name, r + c + 1);
    endtask

    initial begin
        logic [15:0] en_tab [3];
        logic [7:0]  addr_tab [4];

        tests_run         = 0;
        tests_failed      = 0;
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.rd_base_addr  = '0;
        bus.num_rows_read = '0;
        bus.num_cols_read = '0;

        // 1: reset held two cycles
        repeat (2) @(negedge clk);
        check("rst done", 128'(bus.done), 128'(1'b1));
        check("rst rd_en", 128'(bus.rd_en), 128'(0));
        check("rst dvalid", 128'(bus.data_valid), 128'(0));
        check("rst rd_addr", bus.rd_addr, 128'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post-rst done", 128'(bus.done), 128'(1'b1));
        $display("[TB] reset checks done");

        // 2: full 16x16 read at base 0x10
        do_start(8'h10, 4'd15, 4'd15);
        run_seq("t2", 8'h10, 15, 15);
        @(negedge clk);
        check("t2 dvalid clear", 128'(bus.data_valid), 128'(0));

        // 3: three banks, one word each, base 0
        en_tab = '{16'h0001, 16'h0002, 16'h0004};
        do_start(8'h00, 4'd2, 4'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t3 rd_en k=%0d", k), 128'(bus.rd_en), 128'(en_tab[k]));
            check($sformatf("t3 rd_addr k=%0d", k), bus.rd_addr, 128'(0));
            check($sformatf("t3 done k=%0d", k), 128'(bus.done), 128'(1'b0));
            $display("[TB] t3 k=%0d rd_en=%04h", k, bus.rd_en);
            @(negedge clk);
        end
        check("t3 done end", 128'(bus.done), 128'(1'b1));
        check("t3 rd_en end", 128'(bus.rd_en), 128'(0));
        check("t3 dvalid end", 128'(bus.data_valid), 128'(16'h0004));
        @(negedge clk);
        check("t3 dvalid clear", 128'(bus.data_valid), 128'(0));

        // 4: address wrap, with a stray start and new inputs mid-run
        addr_tab = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        do_start(8'hFE, 4'd0, 4'd3);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4 bank0 addr k=%0d", k), 128'(bus.rd_addr[7:0]), 128'(addr_tab[k]));
            check($sformatf("t4 bank1 addr k=%0d", k), 128'(bus.rd_addr[15:8]), 128'(8'hFE));
            check($sformatf("t4 rd_en k=%0d", k), 128'(bus.rd_en), 128'(16'h0001));
            $display("[TB] t4 k=%0d bank0 addr=%02h", k, bus.rd_addr[7:0]);
            if (k == 1) begin
                bus.start         = 1'b1;
                bus.rd_base_addr  = 8'h55;
                bus.num_rows_read = 4'd5;
                bus.num_cols_read = 4'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("t4 done end", 128'(bus.done), 128'(1'b1));
        check("t4 rd_en end", 128'(bus.rd_en), 128'(0));
        @(negedge clk);
        check("t4 still idle", 128'(bus.done), 128'(1'b1));

        // 5: reset on cycle 5 of a full run, then a clean rerun
        do_start(8'h20, 4'd15, 4'd15);
        repeat (5) @(negedge clk);
        check("t5 rd_en k=5", 128'(bus.rd_en), 128'(16'h003F));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5 rst done", 128'(bus.done), 128'(1'b1));
        check("t5 rst rd_en", 128'(bus.rd_en), 128'(0));
        check("t5 rst dvalid", 128'(bus.data_valid), 128'(0));
        check("t5 rst rd_addr", bus.rd_addr, 128'(0));
        $display("[TB] t5 mid-run reset applied");
        do_start(8'h30, 4'd15, 4'd15);
        run_seq("t5", 8'h30, 15, 15);

        // 6: reset and start together, then back-to-back start on done rise
        bus.start         = 1'b1;
        bus.rd_base_addr  = 8'h77;
        bus.num_rows_read = 4'd3;
        bus.num_cols_read = 4'd3;
        reset             = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        check("t6 rst+start done", 128'(bus.done), 128'(1'b1));
        check("t6 rst+start rd_en", 128'(bus.rd_en), 128'(0));
        @(negedge clk);
        check("t6 rst+start idle", 128'(bus.done), 128'(1'b1));
        $display("[TB] t6 reset beat start");
        do_start(8'h00, 4'd1, 4'd1);
        run_seq("t6a", 8'h00, 1, 1);
        do_start(8'h40, 4'd0, 4'd1);
        check("t6b first addr", 128'(bus.rd_addr[7:0]), 128'(8'h40));
        run_seq("t6b", 8'h40, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
